// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared types for the instruction prefetch front end: fetch entries,
// issue FSM states and the instruction word size.
package instruction_prefetch_unit_pkg;

  typedef logic [31:0] uint32_t;

  typedef struct packed {
    uint32_t pc;
    uint32_t instr;
  } fetch_entry_t;

  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    IDLE,
    REQ
  } issue_state_t;

endpackage

// File: rtl/instruction_prefetch_unit_prefetch_fifo.sv
// Synchronous FIFO of fetch entries with flush, a head register output gated
// by occupancy, and an occupancy count used for fetch credit.
module prefetch_fifo
  import instruction_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output logic                         head_valid,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push    = push && !flush;
  assign do_pop     = pop && !flush && (count != '0);
  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; stale contents are never visible because the
  // head is gated by head_valid, so only pointers and count need resetting.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: every sequential assignment uses <= so all registers sample the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Credit accounting upstream must make this unreachable.
  always_ff @(posedge clk) begin
    if (rst && do_push) assert (count != CW'(DEPTH));
  end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Sequential instruction prefetcher: issues Avalon-MM reads ahead of decode,
// buffers responses in a FIFO and discards stale responses after a redirect.
module instruction_prefetch_unit
  import instruction_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH + 1);

  issue_state_t   state, state_next;
  logic [31:0]    fetch_pc, fetch_pc_next;
  logic [31:0]    resp_pc, resp_pc_next;
  logic [31:0]    addr_next, target_pc, launch_pc;
  logic [CW-1:0]  outstanding, out_next;
  logic [CW-1:0]  drop, drop_next;
  logic [CW-1:0]  count, count_next;
  logic           stale, stale_next;
  logic           accept, push, pop, credit;
  fetch_entry_t   push_data, head;

  assign target_pc      = redirect_pc & 32'hFFFF_FFFC;
  assign launch_pc      = redirect ? target_pc : fetch_pc;
  assign avm_read       = (state == REQ);
  assign avm_byteenable = 4'b1111;
  assign accept         = avm_read && !avm_waitrequest;
  assign push           = avm_readdatavalid && (drop == '0) && !redirect;
  assign pop            = instr_valid && instr_ready && !redirect;
  assign out_next       = outstanding + CW'(accept) - CW'(avm_readdatavalid);
  assign count_next     = redirect ? '0 : count + CW'(push) - CW'(pop);
  // Credit covers every read that could still land in the FIFO.
  assign credit         = ((CW+1)'(count_next) + (CW+1)'(out_next)) < (CW+1)'(DEPTH);
  assign busy           = avm_read | (outstanding != '0);
  assign push_data      = '{pc: resp_pc, instr: avm_readdata};
  assign instr_pc       = head.pc;
  assign instr_data     = head.instr;

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (instr_valid),
    .head       (head),
    .count      (count)
  );

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    addr_next     = avm_address;
    fetch_pc_next = launch_pc;
    unique case (state)
      IDLE: begin
        if (credit) begin
          state_next    = REQ;
          addr_next     = launch_pc;
          fetch_pc_next = launch_pc + 32'(INSTR_BYTES);
        end
      end
      REQ: begin
        // A stalled command stays on the bus untouched, even across a redirect.
        if (accept) begin
          if (credit) begin
            addr_next     = launch_pc;
            fetch_pc_next = launch_pc + 32'(INSTR_BYTES);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if (redirect) begin
      drop_next  = out_next;
      stale_next = avm_read && avm_waitrequest;
    end else begin
      // A stalled pre-redirect command joins the drop count once accepted.
      drop_next  = drop - CW'(avm_readdatavalid && (drop != '0))
                        + CW'(accept && stale);
      stale_next = stale && !accept;
    end
    if (redirect)  resp_pc_next = target_pc;
    else if (push) resp_pc_next = resp_pc + 32'(INSTR_BYTES);
    else           resp_pc_next = resp_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      avm_address <= RESET_PC;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      stale       <= 1'b0;
    end else begin
      state       <= state_next;
      avm_address <= addr_next;
      fetch_pc    <= fetch_pc_next;
      resp_pc     <= resp_pc_next;
      outstanding <= out_next;
      drop        <= drop_next;
      stale       <= stale_next;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed bench for instruction_prefetch_unit: per-cycle vector table for
// streaming/stall behaviour plus hand-written redirect and wrap sequences.
module tb_instruction_prefetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        busy;

  instruction_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr_data        (instr_data),
    .instr_pc          (instr_pc),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        wr;
    logic        ready;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_busy;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          lat = 1;
  int          cyc = 0;
  int          pops = 0;
  logic [31:0] exp_pc = RESET_PC;
  pend_t       pend[$];
  logic [31:0] acc_log[$];
  vec_t        tbl[11];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t row(input logic wr, input logic rd, input logic rq,
                               input logic [31:0] addr, input logic v,
                               input logic [31:0] pc, input logic b);
    vec_t r;
    r.wr = wr; r.ready = rd; r.exp_read = rq; r.exp_addr = addr;
    r.exp_valid = v; r.exp_pc = pc; r.exp_busy = b;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Negedge half: consumer model and agent command capture.
  task automatic half_neg();
    @(negedge clk);
    if (rst && instr_valid && instr_ready && !redirect) begin
      check("stream_pc", instr_pc, exp_pc);
      check("stream_data", instr_data, mem_word(exp_pc));
      exp_pc += 32'd4;
      pops++;
    end
    if (rst && avm_read && !avm_waitrequest) begin
      pend.push_back('{addr: avm_address, due: cyc + lat});
      acc_log.push_back(avm_address);
    end
  endtask

  // Posedge half: agent drives any response due in the new cycle.
  task automatic half_pos();
    @(posedge clk);
    #1;
    cyc++;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_word(pend[0].addr);
      pend.delete(0);
    end
  endtask

  task automatic step();
    half_neg();
    half_pos();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    pend.delete();
    acc_log.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", avm_read, 1'b0);
    check("rst_addr", avm_address, RESET_PC);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_data", instr_data, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    cyc = 0;
    pops = 0;
    exp_pc = RESET_PC;
  endtask

  initial begin
    tbl[0]  = row(1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h000, 1'b0);
    tbl[1]  = row(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h000, 1'b1);
    tbl[2]  = row(1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h000, 1'b1);
    tbl[3]  = row(1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 1'b1);
    tbl[4]  = row(1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104, 1'b1);
    tbl[5]  = row(1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108, 1'b1);
    tbl[6]  = row(1'b0, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C, 1'b1);
    tbl[7]  = row(1'b1, 1'b1, 1'b1, 32'h118, 1'b1, 32'h110, 1'b1);
    tbl[8]  = row(1'b0, 1'b1, 1'b1, 32'h118, 1'b1, 32'h114, 1'b1);
    tbl[9]  = row(1'b0, 1'b1, 1'b1, 32'h11C, 1'b0, 32'h000, 1'b1);
    tbl[10] = row(1'b0, 1'b1, 1'b1, 32'h120, 1'b1, 32'h118, 1'b1);

    // Streaming from reset, latency 1, with one waitrequest cycle.
    lat = 1;
    instr_ready = 1'b1;
    do_reset();
    check("byteenable", avm_byteenable, 4'hF);
    for (int i = 0; i < 11; i++) begin
      avm_waitrequest = tbl[i].wr;
      instr_ready     = tbl[i].ready;
      half_neg();
      check($sformatf("v%0d_read", i), avm_read, tbl[i].exp_read);
      check($sformatf("v%0d_addr", i), avm_address, tbl[i].exp_addr);
      check($sformatf("v%0d_valid", i), instr_valid, tbl[i].exp_valid);
      check($sformatf("v%0d_pc", i), instr_pc, tbl[i].exp_pc);
      check($sformatf("v%0d_data", i), instr_data,
            tbl[i].exp_valid ? mem_word(tbl[i].exp_pc) : 32'h0);
      check($sformatf("v%0d_busy", i), busy, tbl[i].exp_busy);
      half_pos();
    end
    avm_waitrequest = 1'b0;

    // Reset asserted mid-stream clears outputs immediately.
    rst = 1'b0;
    #1;
    check("midrst_read", avm_read, 1'b0);
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_addr", avm_address, RESET_PC);

    // Consumer stalled: exactly DEPTH reads, then resume at 0x110 after a pop.
    instr_ready = 1'b0;
    do_reset();
    repeat (12) step();
    check("stall_accepts", acc_log.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < acc_log.size(); i++)
      check($sformatf("stall_addr%0d", i), acc_log[i], RESET_PC + 32'(4 * i));
    check("stall_read_idle", avm_read, 1'b0);
    check("stall_head_pc", instr_pc, RESET_PC);
    instr_ready = 1'b1;
    step();
    check("resume_read", avm_read, 1'b1);
    check("resume_addr", avm_address, 32'h110);
    repeat (8) step();
    check("resume_pops", (pops >= 6), 1'b1);

    // Redirect with three reads outstanding (latency 4).
    lat = 4;
    do_reset();
    repeat (3) step();
    redirect = 1'b1;
    redirect_pc = 32'h2000;
    step();
    redirect = 1'b0;
    exp_pc = 32'h2000;
    check("redir3_accepts", acc_log.size(), 3);
    check("redir3_read", avm_read, 1'b1);
    check("redir3_addr", avm_address, 32'h2000);
    check("redir3_valid", instr_valid, 1'b0);
    repeat (12) step();
    check("redir3_pops", (pops >= 2), 1'b1);

    // Stalled command across a redirect: held, dropped, then 0x2000.
    lat = 1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      redirect        = (c == 2);
      redirect_pc     = 32'h2000;
      avm_waitrequest = (c <= 5);
      step();
      redirect = 1'b0;
      if (c == 2) exp_pc = 32'h2000;
      if (c + 1 <= 6) begin
        check($sformatf("hold%0d_read", c + 1), avm_read, 1'b1);
        check($sformatf("hold%0d_addr", c + 1), avm_address, 32'h100);
      end else if (c + 1 == 7) begin
        check("hold_next_read", avm_read, 1'b1);
        check("hold_next_addr", avm_address, 32'h2000);
      end
    end
    avm_waitrequest = 1'b0;
    repeat (6) step();
    check("hold_pops", (pops >= 4), 1'b1);

    // Redirect coinciding with a response and a pop.
    do_reset();
    repeat (3) step();
    check("coin_pre_valid", instr_valid, 1'b1);
    check("coin_pre_pc", instr_pc, 32'h100);
    redirect = 1'b1;
    redirect_pc = 32'h2003;
    step();
    redirect = 1'b0;
    exp_pc = 32'h2000;
    check("coin_flush_valid", instr_valid, 1'b0);
    check("coin_addr", avm_address, 32'h2000);
    check("coin_busy", busy, 1'b1);
    step();
    check("coin_drop_valid", instr_valid, 1'b0);
    step();
    check("coin_first_valid", instr_valid, 1'b1);
    check("coin_first_pc", instr_pc, 32'h2000);
    check("coin_first_data", instr_data, mem_word(32'h2000));
    repeat (4) step();

    // Address wrap at the top of the address space.
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF9;
    step();
    redirect = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    check("wrap_first_addr", avm_address, 32'hFFFF_FFF8);
    repeat (8) step();
    check("wrap_accepts", (acc_log.size() >= 3), 1'b1);
    if (acc_log.size() >= 3) begin
      check("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
      check("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
      check("wrap_addr2", acc_log[2], 32'h0000_0000);
    end
    check("wrap_pops", (pops >= 3), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch_unit.md
# instruction_prefetch_unit

Parametrised instruction fetch front end that streams sequential 32-bit instruction words from an Avalon-MM read agent into a DEPTH-entry prefetch FIFO. It keeps up to DEPTH reads in flight, delivers {pc, instruction} pairs to the decode stage over a valid/ready handshake, and on a redirect (branch/jump/trap) flushes the FIFO and discards stale in-flight responses. It sits between the core's control path and the instruction bus, replacing the single-request fetch handshake.

## Interface
- DEPTH, 4: prefetch FIFO entries; also the maximum number of reads in flight. Power of two, minimum 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- avm_address  out  32  word-aligned fetch address.
- avm_read  out  1  read command.
- avm_byteenable  out  4  constant 4'b1111.
- avm_waitrequest  in  1  agent stall; command must be held while high.
- avm_readdatavalid  in  1  response valid; responses return in issue order.
- avm_readdata  in  32  response data.
- redirect  in  1  single-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- instr_valid  out  1  instr_data/instr_pc hold a valid entry (FIFO head).
- instr_ready  in  1  consumer accepts the head this cycle.
- instr_data  out  32  instruction word.
- instr_pc  out  32  address of instr_data.
- busy  out  1  reads in flight or a command is on the bus.

## Operation
- Reset values: avm_read=0, avm_address=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, busy=0. Internal state after reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
- Issue state machine, states IDLE and REQ:
  - IDLE → REQ when fifo_count + outstanding < DEPTH. avm_address<=fetch_pc, avm_read<=1.
  - In REQ, while avm_waitrequest=1, avm_read and avm_address are held stable.
  - In REQ with waitrequest=0 the command is accepted: outstanding+1, fetch_pc+=4. The FSM stays in REQ with the next address if credit remains after the increment; otherwise it returns to IDLE.
  - fetch_pc wraps modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- Response path:
  - On readdatavalid, outstanding is decremented.
  - If drop>0: drop is decremented and the data is discarded.
  - Otherwise {resp_pc, readdata} is pushed and resp_pc+=4. resp_pc tracks the address of the next expected response.
  - Credit accounting guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- Consumer: the FIFO pops when instr_valid && instr_ready. Push and pop in the same cycle are both performed.
- Redirect (highest priority):
  - FIFO flushed; instr_valid=0 next cycle.
  - fetch_pc<=redirect_pc and resp_pc<=redirect_pc.
  - drop<=outstanding_next. This counts reads accepted this cycle and excludes any response arriving this cycle; a response arriving in the redirect cycle is itself discarded.
  - If a command is stalled (REQ with waitrequest=1), it stays on the bus unchanged until accepted. It is then counted into drop, and the next command uses redirect_pc.
  - A pop in the redirect cycle is ignored.
  - A redirect during an existing drop period adds to drop.
- busy = avm_read | (outstanding != 0).

## Timing
- Redirect at cycle N with an idle bus: avm_read=1 with avm_address=redirect_pc at N+1.
- readdatavalid at cycle M: instr_valid=1 for that word at M+1 (registered FIFO output).
- Zero-wait agent with fixed read latency L ≤ DEPTH-1 and the consumer always ready: sustained throughput of 1 instruction per cycle.
- Counters outstanding and drop are $clog2(DEPTH+1) bits and never exceed DEPTH.
- Reset asserted mid-operation clears all state immediately. Responses that arrive after reset deasserts are treated as stale protocol errors; the system resets agent and core together.

## Structure
- Package Types gains:
  - fetch_entry_t: packed struct {uint32_t pc; uint32_t instr;}
  - localparam INSTR_BYTES = 4.
- One sub-module: prefetch_fifo, a synchronous FIFO of fetch_entry_t, parameterised by DEPTH, with a flush input, a registered head, and a count output.
- Bus signals are bundled through the existing AvalonMmRead.Host modport. The flat names above document the members.

## Test plan
- Reset with RESET_PC=32'h100, zero-wait agent with latency 1, instr_ready=1 → reads to 0x100, 0x104, 0x108… back-to-back; instr_pc/instr_data stream one per cycle starting 2 cycles after the first accept.
- instr_ready=0, DEPTH=4 → exactly 4 reads issued, then avm_read stays 0; raising instr_ready resumes issue at 0x110 the cycle after the first pop.
- Redirect to 32'h2000 with 3 reads outstanding → those 3 responses are dropped, no instr_valid before the 0x2000 word, and the first delivered instr_pc=0x2000.
- waitrequest held high for 5 cycles with a redirect in cycle 2 → address stays stable until accepted; its response is dropped; the next command addresses 0x2000.
- Redirect in the same cycle as readdatavalid and as a pop → that response is dropped, the FIFO is empty next cycle, and drop equals the remaining outstanding count.
- fetch_pc=32'hFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 are issued, and instr_pc wraps identically.
